// File: rtl/half_accumulate_sequencer.sv
// Issue sequencer for the FP16 add-accumulate stage: takes a stream of operand
// pairs, clears the accumulator, spaces issues by ISSUE_GAP, waits for the
// pipeline to drain and hands the captured sum out on a valid/ready port.
module half_accumulate_sequencer #(
  parameter int MAX_TERMS    = 64,
  parameter int ISSUE_GAP    = 4,
  parameter int DRAIN_CYCLES = 5,
  localparam int CW          = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [15:0]   s_a,
  input  logic [15:0]   s_b,
  input  logic          s_last,
  output logic          acc_clear,
  output logic          acc_in_valid,
  output logic [15:0]   acc_a,
  output logic [15:0]   acc_b,
  input  logic [15:0]   acc_c,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   m_data,
  output logic [CW-1:0] m_count,
  output logic          m_trunc,
  output logic          m_nan,
  output logic          m_inf
);

  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LD = GW'(ISSUE_GAP - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, OUT} state_e;

  state_e        state_q;
  logic [CW-1:0] term_q, term_d;
  logic [GW-1:0] gap_q;
  logic [DW-1:0] drain_q;
  logic          trunc_q;
  logic          s_ready_q, acc_clear_q, acc_in_valid_q;
  logic [15:0]   acc_a_q, acc_b_q;
  logic          m_valid_q, m_trunc_q, m_nan_q, m_inf_q;
  logic [15:0]   m_data_q;
  logic [CW-1:0] m_count_q;
  logic          accept, hit_max, vec_end;

  // Handshake and end-of-vector decode for the current ISSUE cycle.
  always_comb begin
    accept  = s_valid && s_ready_q;
    term_d  = term_q + CW'(1);
    hit_max = (term_d == CW'(MAX_TERMS));
    vec_end = s_last || hit_max;
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      term_q         <= '0;
      gap_q          <= '0;
      drain_q        <= '0;
      trunc_q        <= 1'b0;
      s_ready_q      <= 1'b0;
      acc_clear_q    <= 1'b0;
      acc_in_valid_q <= 1'b0;
      acc_a_q        <= '0;
      acc_b_q        <= '0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_count_q      <= '0;
      m_trunc_q      <= 1'b0;
      m_nan_q        <= 1'b0;
      m_inf_q        <= 1'b0;
    end else begin
      acc_clear_q    <= 1'b0;
      acc_in_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            state_q     <= CLEAR;
            acc_clear_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q   <= ISSUE;
          term_q    <= '0;
          gap_q     <= '0;
          trunc_q   <= 1'b0;
          s_ready_q <= 1'b1;
        end
        ISSUE: begin
          if (accept) begin
            acc_in_valid_q <= 1'b1;
            acc_a_q        <= s_a;
            acc_b_q        <= s_b;
            term_q         <= term_d;
            if (vec_end) begin
              state_q   <= DRAIN;
              drain_q   <= DW'(DRAIN_CYCLES);
              trunc_q   <= hit_max && !s_last;
              gap_q     <= '0;
              s_ready_q <= 1'b0;
            end else begin
              gap_q     <= GAP_LD;
              s_ready_q <= (GAP_LD == '0);
            end
          end else if (gap_q != '0) begin
            gap_q     <= gap_q - GW'(1);
            s_ready_q <= (gap_q == GW'(1));
          end
        end
        DRAIN: begin
          // The cycle carrying the final issue pulse is not counted.
          if (!acc_in_valid_q) begin
            if (drain_q == DW'(1)) begin
              state_q   <= OUT;
              m_valid_q <= 1'b1;
              m_data_q  <= acc_c;
              m_count_q <= term_q;
              m_trunc_q <= trunc_q;
              m_nan_q   <= (acc_c[14:10] == 5'h1F) && (acc_c[9:0] != '0);
              m_inf_q   <= (acc_c[14:10] == 5'h1F) && (acc_c[9:0] == '0);
            end else begin
              drain_q <= drain_q - DW'(1);
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign acc_clear    = acc_clear_q;
  assign acc_in_valid = acc_in_valid_q;
  assign acc_a        = acc_a_q;
  assign acc_b        = acc_b_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_count      = m_count_q;
  assign m_trunc      = m_trunc_q;
  assign m_nan        = m_nan_q;
  assign m_inf        = m_inf_q;

endmodule

// File: tb/tb_half_accumulate_sequencer.sv
// Bench for half_accumulate_sequencer: drives operand pairs, models the FP16
// accumulator behind the DUT, and checks results against a real-valued sum.
module tb_half_accumulate_sequencer;
  localparam int MT = 64, G = 4, D = 5;
  localparam int CW = $clog2(MT + 1);

  logic clk = 0, rst = 1;
  logic s_valid = 0, s_ready, s_last = 0;
  logic [15:0] s_a = 0, s_b = 0;
  logic acc_clear, acc_in_valid;
  logic [15:0] acc_a, acc_b, acc_c = 0;
  logic m_valid, m_ready = 1;
  logic [15:0] m_data;
  logic [CW-1:0] m_count;
  logic m_trunc, m_nan, m_inf;

  half_accumulate_sequencer #(.MAX_TERMS(MT), .ISSUE_GAP(G), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .acc_clear(acc_clear), .acc_in_valid(acc_in_valid), .acc_a(acc_a),
    .acc_b(acc_b), .acc_c(acc_c), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_count(m_count), .m_trunc(m_trunc), .m_nan(m_nan), .m_inf(m_inf));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  typedef struct { logic [15:0] d; int n; bit tr; bit nan; bit inf; } res_t;

  // ---------------- FP16 helpers ----------------
  function automatic real f16_fin(input logic [15:0] h);
    real v; int e;
    e = int'(h[14:10]);
    if (e == 31) return 0.0;
    if (e == 0) v = real'(h[9:0]) / 16777216.0;
    else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      for (int i = 0; i < e - 15; i++) v = v * 2.0;
      for (int i = 0; i < 15 - e; i++) v = v / 2.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic bit f16_pinf(input logic [15:0] h); return h == 16'h7C00; endfunction
  function automatic bit f16_ninf(input logic [15:0] h); return h == 16'hFC00; endfunction
  function automatic bit f16_isnan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 0);
  endfunction

  function automatic logic [15:0] f16_enc(input real x, input bit pi, input bit ni, input bit nn);
    real m; int e; int mi; logic s;
    if (nn || (pi && ni)) return 16'h7E00;
    if (pi) return 16'h7C00;
    if (ni) return 16'hFC00;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e >= 31) return s ? 16'hFC00 : 16'h7C00;
    mi = int'((m - 1.0) * 1024.0);
    return {s, e[4:0], mi[9:0]};
  endfunction

  function automatic logic [15:0] rnd_f16();
    return f16_enc(real'($urandom_range(15, 0)), 0, 0, 0);
  endfunction

  // ---------------- accumulator plant (2-cycle result latency) ----------------
  real acc_sum = 0.0;
  bit acc_pi = 0, acc_ni = 0, acc_nn = 0;
  logic [15:0] acc_p1 = 0;
  always @(posedge clk) begin
    if (acc_clear) begin
      acc_sum <= 0.0; acc_pi <= 0; acc_ni <= 0; acc_nn <= 0;
    end else if (acc_in_valid) begin
      acc_sum <= acc_sum + f16_fin(acc_a) + f16_fin(acc_b);
      acc_pi  <= acc_pi | f16_pinf(acc_a) | f16_pinf(acc_b);
      acc_ni  <= acc_ni | f16_ninf(acc_a) | f16_ninf(acc_b);
      acc_nn  <= acc_nn | f16_isnan(acc_a) | f16_isnan(acc_b);
    end
    acc_p1 <= f16_enc(acc_sum, acc_pi, acc_ni, acc_nn);
    acc_c  <= acc_p1;
  end

  // ---------------- event monitor ----------------
  int acc_cyc[$], iss_cyc[$], clr_cyc[$];
  logic [31:0] iss_ab[$];
  res_t got_q[$];
  int rdy_n = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid && s_ready) acc_cyc.push_back(cyc);
      if (acc_in_valid) begin iss_cyc.push_back(cyc); iss_ab.push_back({acc_a, acc_b}); end
      if (acc_clear) clr_cyc.push_back(cyc);
      if (s_ready) rdy_n++;
      if (m_valid && m_ready) got_q.push_back('{m_data, int'(m_count), m_trunc, m_nan, m_inf});
    end
  end

  // ---------------- reference model: vector sums from the sent pairs ----------------
  real r_sum = 0.0;
  bit r_pi = 0, r_ni = 0, r_nn = 0;
  int r_n = 0;
  res_t exp_q[$];
  int got_rd = 0;
  res_t last_g;

  task automatic ref_clear();
    r_sum = 0.0; r_pi = 0; r_ni = 0; r_nn = 0; r_n = 0;
  endtask

  task automatic ref_add(input logic [15:0] a, input logic [15:0] b, input bit last);
    res_t e;
    r_sum = r_sum + f16_fin(a) + f16_fin(b);
    r_pi = r_pi | f16_pinf(a) | f16_pinf(b);
    r_ni = r_ni | f16_ninf(a) | f16_ninf(b);
    r_nn = r_nn | f16_isnan(a) | f16_isnan(b);
    r_n++;
    if (last || r_n == MT) begin
      e.d = f16_enc(r_sum, r_pi, r_ni, r_nn);
      e.n = r_n; e.tr = !last;
      e.nan = (e.d[14:10] == 5'h1F) && (e.d[9:0] != 0);
      e.inf = (e.d[14:10] == 5'h1F) && (e.d[9:0] == 0);
      exp_q.push_back(e);
      ref_clear();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit last);
    bit ok;
    ok = 0;
    s_valid = 1; s_a = a; s_b = b; s_last = last;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
    if (ok) ref_add(a, b, last);
  endtask

  task automatic chk_res(input string tag);
    bit ok;
    res_t e, g;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (got_q.size() > got_rd) ok = 1;
    end
    if (!ok) begin chk({tag, "_timeout"}, 0, 1); return; end
    g = got_q[got_rd]; got_rd++;
    if (exp_q.size() == 0) begin chk({tag, "_noexp"}, 0, 1); return; end
    e = exp_q.pop_front();
    chk({tag, "_data"}, g.d, e.d);
    chk({tag, "_count"}, g.n, e.n);
    chk({tag, "_trunc"}, g.tr, e.tr);
    chk({tag, "_nan"}, g.nan, e.nan);
    chk({tag, "_inf"}, g.inf, e.inf);
    last_g = g;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ib, cb, ab, r0, g0;
    bit ok;
    logic [15:0] pa[8], pb[8];

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_acc_in_valid", acc_in_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_count", m_count, 0);
    chk("rst_acc_a", acc_a, 0);
    @(posedge clk); #1 rst = 0;

    // four (1.0, 1.0) pairs
    ib = iss_cyc.size(); cb = clr_cyc.size();
    for (int i = 0; i < 4; i++) send_pair(16'h3C00, 16'h3C00, i == 3);
    chk_res("t1");
    chk("t1_data_8p0", last_g.d, 16'h4800);
    chk("t1_clears", clr_cyc.size() - cb, 1);
    chk("t1_issues", iss_cyc.size() - ib, 4);
    if (clr_cyc.size() > cb && iss_cyc.size() > ib)
      chk("t1_clear_first", clr_cyc[cb] < iss_cyc[ib], 1);
    for (int i = 1; i < 4; i++)
      if (iss_cyc.size() > ib + i) chk("t1_gap", iss_cyc[ib+i] - iss_cyc[ib+i-1], G);

    // continuous s_valid, random pairs
    ib = iss_cyc.size(); ab = acc_cyc.size(); r0 = rdy_n;
    for (int i = 0; i < 6; i++) begin pa[i] = rnd_f16(); pb[i] = rnd_f16(); end
    for (int i = 0; i < 6; i++) send_pair(pa[i], pb[i], i == 5);
    chk_res("t2");
    chk("t2_ready_cycles", rdy_n - r0, 6);
    for (int i = 0; i < 6; i++) begin
      if (iss_cyc.size() > ib + i && acc_cyc.size() > ab + i) begin
        chk("t2_latency", iss_cyc[ib+i] - acc_cyc[ab+i], 1);
        chk("t2_operands", iss_ab[ib+i], {pa[i], pb[i]});
        if (i > 0) chk("t2_accept_gap", acc_cyc[ab+i] - acc_cyc[ab+i-1], G);
      end
    end

    // 65 pairs without last: truncation at MAX_TERMS then a one-pair vector
    cb = clr_cyc.size();
    for (int i = 0; i < MT; i++) send_pair(rnd_f16(), rnd_f16(), 0);
    send_pair(rnd_f16(), rnd_f16(), 1);
    chk_res("t3a");
    chk("t3a_count64", last_g.n, 64);
    chk("t3a_trunc1", last_g.tr, 1);
    chk_res("t3b");
    chk("t3b_count1", last_g.n, 1);
    chk("t3b_trunc0", last_g.tr, 0);
    chk("t3_clears", clr_cyc.size() - cb, 2);

    // special values
    send_pair(16'h7C00, 16'hFC00, 1);
    chk_res("t4nan");
    chk("t4_nan_flag", last_g.nan, 1);
    chk("t4_nan_inf0", last_g.inf, 0);
    send_pair(16'h7C00, 16'h3C00, 1);
    chk_res("t4inf");
    chk("t4_inf_flag", last_g.inf, 1);
    chk("t4_inf_data", last_g.d, 16'h7C00);

    // back-pressure on the result port
    m_ready = 0;
    send_pair(rnd_f16(), rnd_f16(), 0);
    send_pair(rnd_f16(), rnd_f16(), 1);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); if (m_valid) ok = 1; end
    if (!ok) chk("t5_mvalid_timeout", 0, 1);
    ib = iss_cyc.size(); cb = clr_cyc.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", m_valid, 1);
      chk("t5_hold_data", m_data, exp_q.size() > 0 ? exp_q[0].d : 16'hxxxx);
      chk("t5_hold_sready", s_ready, 0);
    end
    chk("t5_no_issue", iss_cyc.size() - ib, 0);
    chk("t5_no_clear", clr_cyc.size() - cb, 0);
    @(posedge clk); #1 m_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_valid_drop", m_valid, 0);
    chk_res("t5");

    // reset mid-vector discards it
    g0 = got_q.size();
    send_pair(rnd_f16(), rnd_f16(), 0);
    send_pair(rnd_f16(), rnd_f16(), 0);
    rst = 1;
    ref_clear();
    @(posedge clk);
    @(negedge clk);
    chk("t6_s_ready", s_ready, 0);
    chk("t6_acc_in_valid", acc_in_valid, 0);
    chk("t6_acc_a", acc_a, 0);
    chk("t6_acc_b", acc_b, 0);
    chk("t6_m_valid", m_valid, 0);
    @(posedge clk); #1 rst = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_result", got_q.size() - g0, 0);
    for (int i = 0; i < 4; i++) send_pair(rnd_f16(), rnd_f16(), i == 3);
    chk_res("t6");
    chk("t6_count4", last_g.n, 4);

    // random vectors with idle gaps on the input
    for (int v = 0; v < 4; v++) begin
      int len;
      len = $urandom_range(8, 1);
      for (int i = 0; i < len; i++) begin
        send_pair(rnd_f16(), rnd_f16(), i == len - 1);
        repeat ($urandom_range(3, 0)) @(posedge clk);
        #1;
      end
      chk_res("t7");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
